// File: rtl/gemini_pkg.sv
// Shared types and sizing for the fetch/decode instruction queue.
package gemini_pkg;

    localparam int IQ_DEPTH = 16;
    localparam int EXP_W    = 14;
    localparam int IQ_PTR_W = $clog2(IQ_DEPTH);
    localparam int IQ_CNT_W = IQ_PTR_W + 1;

    typedef struct packed {
        logic [31:0]      instr;
        logic [31:0]      pc;
        logic [EXP_W-1:0] exp;
    } iq_entry_t;

    // Fetch and issue counts only ever mean 0, 1 or 2; an encoding of 3 saturates to 2.
    function automatic logic [1:0] clamp2(input logic [1:0] v);
        return (v == 2'd3) ? 2'd2 : v;
    endfunction

endpackage

// File: rtl/iq_ram.sv
// Instruction-queue storage: two write ports, two asynchronous read ports, no reset.
module iq_ram
    import gemini_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    parameter int AW    = IQ_PTR_W
) (
    input  logic            clk,
    input  logic            we0,
    input  logic [AW-1:0]   wa0,
    input  iq_entry_t       wd0,
    input  logic            we1,
    input  logic [AW-1:0]   wa1,
    input  iq_entry_t       wd1,
    input  logic [AW-1:0]   ra0,
    input  logic [AW-1:0]   ra1,
    output iq_entry_t       rd0,
    output iq_entry_t       rd1
);

    iq_entry_t mem [DEPTH];

    // Port 1 is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (we0) mem[wa0] <= wd0;
        if (we1) mem[wa1] <= wd1;
    end

    assign rd0 = mem[ra0];
    assign rd1 = mem[ra1];

endmodule

// File: rtl/inst_queue.sv
// Dual-issue instruction queue between fetch and decode; circular buffer with count register.
// Optional same-cycle bypass on an empty queue is enabled by defining INST_QUEUE_BYPASS_EN.
module inst_queue
    import gemini_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    parameter int EXP_W = gemini_pkg::EXP_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [1:0]                in_count,
    input  logic [31:0]               in_instr0,
    input  logic [31:0]               in_instr1,
    input  logic [31:0]               in_pc0,
    input  logic [31:0]               in_pc1,
    input  logic [EXP_W-1:0]          in_exp0,
    input  logic [EXP_W-1:0]          in_exp1,
    output logic                      in_ready,
    input  logic [1:0]                issue_count,
    output logic [31:0]               Instr_First,
    output logic [31:0]               Instr_Second,
    output logic [31:0]               PC_First_out,
    output logic [31:0]               PC_Second_out,
    output logic [EXP_W-1:0]          Exp_First_out,
    output logic [EXP_W-1:0]          Exp_Second_out,
    output logic                      valid_first,
    output logic                      valid_second,
    output logic [$clog2(DEPTH):0]    occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr_nx1;
    logic [PTR_W-1:0] wr_ptr_nx1;

    logic [1:0] push_req;
    logic [1:0] issue_req;
    logic [1:0] push_n;
    logic [1:0] show_n;
    logic [1:0] avail_n;
    logic [1:0] pop_n;
    logic [1:0] wr_n;
    logic [1:0] rd_adv;
    logic       bypass;
    logic       we0;
    logic       we1;

    iq_entry_t in_e0, in_e1, wd0, wd1, rd0, rd1, out0, out1;

    assign in_e0      = '{instr: in_instr0, pc: in_pc0, exp: in_exp0};
    assign in_e1      = '{instr: in_instr1, pc: in_pc1, exp: in_exp1};
    assign rd_ptr_nx1 = rd_ptr + 1'b1;
    assign wr_ptr_nx1 = wr_ptr + 1'b1;
    assign push_req   = clamp2(in_count);
    assign issue_req  = clamp2(issue_count);

    // Fetch handshake: in_count entries are taken on a rising edge only if in_ready is high
    // in that cycle (and no flush); otherwise the push is dropped and fetch must retry.
    assign in_ready  = (count <= CNT_W'(DEPTH - 2));
    assign occupancy = count;
    assign show_n    = (count == '0) ? 2'd0 : ((count == CNT_W'(1)) ? 2'd1 : 2'd2);

    always_comb begin
        bypass = 1'b0;
`ifdef INST_QUEUE_BYPASS_EN
        bypass = (count == '0) && !flush;
`endif
        push_n  = in_ready ? push_req : 2'd0;
        avail_n = bypass ? push_n : show_n;
        pop_n   = (issue_req < avail_n) ? issue_req : avail_n;
        // Bypassed entries that decode consumes this cycle never touch storage.
        wr_n    = bypass ? (push_n - pop_n) : push_n;
        rd_adv  = bypass ? 2'd0 : pop_n;
        wd0     = (bypass && (pop_n == 2'd1)) ? in_e1 : in_e0;
        wd1     = in_e1;
        we0     = !flush && (wr_n != 2'd0);
        we1     = !flush && (wr_n == 2'd2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            rd_ptr <= wr_ptr;
        end else begin
            count  <= count + CNT_W'(wr_n) - CNT_W'(rd_adv);
            rd_ptr <= rd_ptr + PTR_W'(rd_adv);
            wr_ptr <= wr_ptr + PTR_W'(wr_n);
        end
    end

    iq_ram #(
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_ram (
        .clk (clk),
        .we0 (we0),
        .wa0 (wr_ptr),
        .wd0 (wd0),
        .we1 (we1),
        .wa1 (wr_ptr_nx1),
        .wd1 (wd1),
        .ra0 (rd_ptr),
        .ra1 (rd_ptr_nx1),
        .rd0 (rd0),
        .rd1 (rd1)
    );

    // Invalid slots present an all-zero nop so decode never sees stale storage.
    always_comb begin
        valid_first  = bypass ? (push_n != 2'd0) : (count != '0);
        valid_second = bypass ? (push_n == 2'd2) : (count > CNT_W'(1));
        out0 = bypass ? in_e0 : rd0;
        out1 = bypass ? in_e1 : rd1;
        if (!valid_first)  out0 = '0;
        if (!valid_second) out1 = '0;
    end

    assign Instr_First    = out0.instr;
    assign Instr_Second   = out1.instr;
    assign PC_First_out   = out0.pc;
    assign PC_Second_out  = out1.pc;
    assign Exp_First_out  = out0.exp;
    assign Exp_Second_out = out1.exp;

endmodule

// File: tb/tb_inst_queue.sv
// Bench for inst_queue (default build): directed steps plus random traffic against a queue model.
module tb_inst_queue;

    localparam int DEPTH = 16;
    localparam int EXP_W = 14;
    localparam int EW    = 64 + EXP_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic [1:0]        in_count;
    logic [31:0]       in_instr0, in_instr1, in_pc0, in_pc1;
    logic [EXP_W-1:0]  in_exp0, in_exp1;
    logic              in_ready;
    logic [1:0]        issue_count;
    logic [31:0]       Instr_First, Instr_Second, PC_First_out, PC_Second_out;
    logic [EXP_W-1:0]  Exp_First_out, Exp_Second_out;
    logic              valid_first, valid_second;
    logic [4:0]        occupancy;

    logic [EW-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    inst_queue #(.DEPTH(DEPTH), .EXP_W(EXP_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_count       (in_count),
        .in_instr0      (in_instr0),
        .in_instr1      (in_instr1),
        .in_pc0         (in_pc0),
        .in_pc1         (in_pc1),
        .in_exp0        (in_exp0),
        .in_exp1        (in_exp1),
        .in_ready       (in_ready),
        .issue_count    (issue_count),
        .Instr_First    (Instr_First),
        .Instr_Second   (Instr_Second),
        .PC_First_out   (PC_First_out),
        .PC_Second_out  (PC_Second_out),
        .Exp_First_out  (Exp_First_out),
        .Exp_Second_out (Exp_Second_out),
        .valid_first    (valid_first),
        .valid_second   (valid_second),
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        int sz;
        logic [EW-1:0] h0, h1;
        sz = exp_q.size();
        h0 = (sz >= 1) ? exp_q[0] : '0;
        h1 = (sz >= 2) ? exp_q[1] : '0;
        check("occupancy",     32'(occupancy),     32'(sz));
        check("in_ready",      32'(in_ready),      32'(sz <= DEPTH - 2));
        check("valid_first",   32'(valid_first),   32'(sz >= 1));
        check("valid_second",  32'(valid_second),  32'(sz >= 2));
        check("instr_first",   Instr_First,        h0[EW-1:EW-32]);
        check("pc_first",      PC_First_out,       h0[EW-33:EXP_W]);
        check("exp_first",     32'(Exp_First_out), 32'(h0[EXP_W-1:0]));
        check("instr_second",  Instr_Second,       h1[EW-1:EW-32]);
        check("pc_second",     PC_Second_out,      h1[EW-33:EXP_W]);
        check("exp_second",    32'(Exp_Second_out), 32'(h1[EXP_W-1:0]));
    endtask

    // One clock: drive inputs, apply the queue rules to the model at the edge, check at negedge.
    task automatic cycle(input logic r, input logic fl, input logic [1:0] ic,
                         input logic [1:0] isc, input logic [31:0] pc0, input logic [31:0] pc1);
        int sz, np, ni, shown;
        logic [EW-1:0] e0, e1;
        e0 = {$urandom(), pc0, EXP_W'($urandom())};
        e1 = {$urandom(), pc1, EXP_W'($urandom())};
        rst = r; flush = fl; in_count = ic; issue_count = isc;
        in_instr0 = e0[EW-1:EW-32]; in_pc0 = e0[EW-33:EXP_W]; in_exp0 = e0[EXP_W-1:0];
        in_instr1 = e1[EW-1:EW-32]; in_pc1 = e1[EW-33:EXP_W]; in_exp1 = e1[EXP_W-1:0];
        @(posedge clk);
        sz = exp_q.size();
        if (r || fl) begin
            exp_q.delete();
        end else begin
            np = (ic >= 2) ? 2 : int'(ic);
            ni = (isc >= 2) ? 2 : int'(isc);
            shown = (sz >= 2) ? 2 : sz;
            if (ni > shown) ni = shown;
            for (int k = 0; k < ni; k++) void'(exp_q.pop_front());
            if (sz <= DEPTH - 2) begin
                if (np >= 1) exp_q.push_back(e0);
                if (np == 2) exp_q.push_back(e1);
            end
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_count = '0; issue_count = '0;
        in_instr0 = '0; in_instr1 = '0; in_pc0 = '0; in_pc1 = '0; in_exp0 = '0; in_exp1 = '0;

        // Reset state
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 2, 2, 32'h1, 32'h2);

        // Push two, hold, then issue both
        cycle(0, 0, 2, 0, 32'h1000, 32'h1004);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 2, 0, 0);

        // Fill to DEPTH-1 from a fresh reset so the write pointer ends at 15
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) cycle(0, 0, 2, 0, 32'h3000 + 8 * i, 32'h3004 + 8 * i);
        cycle(0, 0, 1, 0, 32'h3100, 0);
        cycle(0, 0, 2, 1, 32'hdead, 32'hbeef);   // dropped push, ready low despite the pop
        cycle(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 7; i++) cycle(0, 0, 0, 2, 0, 0);

        // Wrap-around push at slots 15 and 0, popped in order
        cycle(0, 0, 2, 0, 32'h4000, 32'h4004);
        cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);

        // Over-issue clamp
        cycle(0, 0, 1, 0, 32'h5000, 0);
        cycle(0, 0, 0, 2, 0, 0);
        cycle(0, 0, 0, 3, 0, 0);

        // Flush beats simultaneous push and pop; next push lands at the head
        cycle(0, 0, 3, 0, 32'h6000, 32'h6004);
        cycle(0, 1, 2, 1, 32'h6100, 32'h6104);
        cycle(0, 0, 2, 0, 32'h7000, 32'h7004);
        cycle(0, 0, 0, 1, 0, 0);

        // Random traffic including occasional flush and reset
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 24) == 0),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom(), $urandom());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
